// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, controller states and op-decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_abs_neg.sv
// Combinational two's-complement conditional negate, used both for operand
// magnitudes and for the final sign corrections of product/quotient/remainder.
module abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (-x) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one shift-add or
// restoring shift-subtract step per clock, then a sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, next_state;

  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic                 div_q, neg_q, neg_rem, div_zero;

  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, shifted, trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 quo_neg;

  assign sign_a = is_signed(op) & a[WIDTH-1];
  assign sign_b = is_signed(op) & b[WIDTH-1];

  abs_neg #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(sign_a), .y(mag_a));
  abs_neg #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(sign_b), .y(mag_b));

  // acc = {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign trial    = shifted - {1'b0, opb};
  assign div_next = trial[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

  // Divide-by-zero forces LO to all ones, so the quotient correction is skipped
  assign quo_neg = neg_q & ~div_zero;

  abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.x(acc), .neg(neg_q), .y(prod_fix));
  abs_neg #(.WIDTH(WIDTH)) u_fix_quo (.x(acc[WIDTH-1:0]), .neg(quo_neg), .y(quo_fix));
  abs_neg #(.WIDTH(WIDTH)) u_fix_rem (.x(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem), .y(rem_fix));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) next_state = CALC;
      CALC: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) next_state = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      opb      <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            div_q    <= is_div(op);
            neg_q    <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (b == '0);
            count    <= '0;
            opb      <= is_div(op) ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (is_div(op) ? mag_a : mag_b)};
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          acc   <= div_q ? div_next : mul_next;
        end
        FIX: begin
          if (div_q) begin
            lo <= div_zero ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// busy/done timing, MTHI/MTLO writes, ignored starts and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycles, busy_cnt;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Launches one operation and waits (bounded) for done; operands are scrambled after accept
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int cyc, output int bcnt);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = OP_MULT; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cycles, busy_cnt);
    n_cmp++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL multu_latency: got %0d expected 33", cycles); end
    n_cmp++; if (busy_cnt !== 33) begin n_fail++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", busy_cnt); end
    n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", hi); end
    n_cmp++; if (lo !== 32'h00000001) begin n_fail++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL multu_done_width: got %b expected 0", done); end
  endtask

  task automatic test_mult;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, cycles, busy_cnt);
    n_cmp++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL mult_latency: got %0d expected 33", cycles); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("[TB] FAIL mult_lo: got %h expected ffffffeb", lo); end
  endtask

  task automatic test_div;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cycles, busy_cnt);
    n_cmp++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL div_latency: got %0d expected 33", cycles); end
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("[TB] FAIL div_quotient: got %h expected fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL div_remainder: got %h expected ffffffff", hi); end
    run_op(OP_DIVU, 32'd100, 32'd7, cycles, busy_cnt);
    n_cmp++; if (lo !== 32'd14) begin n_fail++; $display("[TB] FAIL divu_quotient: got %h expected 0000000e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_fail++; $display("[TB] FAIL divu_remainder: got %h expected 00000002", hi); end
  endtask

  task automatic test_div_boundaries;
    run_op(OP_DIV, 32'h12345678, 32'h0, cycles, busy_cnt);
    n_cmp++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL divzero_latency: got %0d expected 33", cycles); end
    n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL divzero_lo: got %h expected ffffffff", lo); end
    n_cmp++; if (hi !== 32'h12345678) begin n_fail++; $display("[TB] FAIL divzero_hi: got %h expected 12345678", hi); end
    run_op(OP_DIVU, 32'h87654321, 32'h0, cycles, busy_cnt);
    n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL divuzero_lo: got %h expected ffffffff", lo); end
    n_cmp++; if (hi !== 32'h87654321) begin n_fail++; $display("[TB] FAIL divuzero_hi: got %h expected 87654321", hi); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cycles, busy_cnt);
    n_cmp++; if (lo !== 32'h80000000) begin n_fail++; $display("[TB] FAIL overflow_lo: got %h expected 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("[TB] FAIL overflow_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_busy_ignore;
    @(posedge clk); #1;
    op = OP_MULTU; a = 32'h00010000; b = 32'h00030005; start = 1'b1;
    @(posedge clk); #1;
    op = OP_DIV; a = 32'd5; b = 32'd1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("[TB] FAIL busy_hi_hold: got %h expected 00000000", hi); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_running: got %b expected 1", busy); end
    cycles = 1;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_cmp++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL busy_latency: got %0d expected 33", cycles); end
    n_cmp++; if (hi !== 32'h00000003) begin n_fail++; $display("[TB] FAIL busy_result_hi: got %h expected 00000003", hi); end
    n_cmp++; if (lo !== 32'h00050000) begin n_fail++; $display("[TB] FAIL busy_result_lo: got %h expected 00050000", lo); end
  endtask

  task automatic test_mthi_mtlo;
    @(posedge clk); #1;
    lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    lo_we = 1'b0;
    n_cmp++; if (lo !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL mtlo_lo: got %h expected cafef00d", lo); end
    n_cmp++; if (hi !== 32'h00000003) begin n_fail++; $display("[TB] FAIL mtlo_hi_kept: got %h expected 00000003", hi); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL mtlo_done: got %b expected 0", done); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11223344;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    n_cmp++; if (hi !== 32'h11223344) begin n_fail++; $display("[TB] FAIL both_hi: got %h expected 11223344", hi); end
    n_cmp++; if (lo !== 32'h11223344) begin n_fail++; $display("[TB] FAIL both_lo: got %h expected 11223344", lo); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL both_done: got %b expected 0", done); end
  endtask

  task automatic test_start_beats_write;
    @(posedge clk); #1;
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'h00000055;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    n_cmp++; if (hi !== 32'h11223344) begin n_fail++; $display("[TB] FAIL startwin_hi_hold: got %h expected 11223344", hi); end
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_cmp++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL startwin_latency: got %0d expected 33", cycles); end
    n_cmp++; if (hi !== 32'd2) begin n_fail++; $display("[TB] FAIL startwin_hi: got %h expected 00000002", hi); end
    n_cmp++; if (lo !== 32'd14) begin n_fail++; $display("[TB] FAIL startwin_lo: got %h expected 0000000e", lo); end
  endtask

  task automatic test_reset_mid_op;
    @(posedge clk); #1;
    op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_hi: got %h expected 00000000", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_lo: got %h expected 00000000", lo); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(OP_MULT, 32'd5, 32'hFFFFFFFC, cycles, busy_cnt);
    n_cmp++; if (cycles !== 33) begin n_fail++; $display("[TB] FAIL postrst_latency: got %0d expected 33", cycles); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL postrst_hi: got %h expected ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFEC) begin n_fail++; $display("[TB] FAIL postrst_lo: got %h expected ffffffec", lo); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_boundaries();
    test_busy_ignore();
    test_mthi_mtlo();
    test_start_beats_write();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
